burst_pulse_generator: RTL and testbench
========================================

BURST_PULSE_GENERATOR -- requirements
Module: burst_pulse_generator

Interface
REQ-001 Parameter SIZE, default 8, width of period and width fields.
REQ-002 Parameter CNT_SIZE, default 8, width of burst count and period counter.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst_n  input  1  synchronous active-low reset, sampled on rising Clk.
REQ-005 Start  input  1  launch request; sampled only in IDLE.
REQ-006 Stop  input  1  abort request; effective in any state.
REQ-007 Mode  input  2  00 continuous, 01 burst, 10 single, 11 single (reserved).
REQ-008 Ticks  input  SIZE  period length minus one; period = Ticks+1 cycles.
REQ-009 Width  input  SIZE  number of high cycles at the start of each period.
REQ-010 Count  input  CNT_SIZE  number of periods in burst mode.
REQ-011 Pulse  output  1  registered pulse train.
REQ-012 Busy  output  1  high in RUN state.
REQ-013 Done  output  1  one-cycle completion strobe.
REQ-014 PeriodCount  output  CNT_SIZE  periods completed in current or last run.

Function
REQ-015 FSM states IDLE, RUN, DONE; all outputs registered.
REQ-016 IDLE: Start=1 and Stop=0 at edge t -> latch Mode/Ticks/Width/Count, phase=0, PeriodCount=0, enter RUN; Busy=1 from cycle t+1.
REQ-017 Burst mode with Count=0: Start -> DONE directly; no Pulse; Done high at t+1; Busy stays 0.
REQ-018 RUN: phase counts 0..Ticks, wraps to 0; each wrap increments PeriodCount (wraps modulo 2^CNT_SIZE in continuous mode).
REQ-019 Pulse=1 in every RUN cycle with phase < Width; first high cycle is t+1.
REQ-020 Width=0 -> Pulse never asserts but periods still counted; Width >= Ticks+1 -> Pulse constantly high in RUN.
REQ-021 Ticks=0 -> 1-cycle period; PeriodCount increments every RUN cycle.
REQ-022 Inputs Mode/Ticks/Width/Count changing during RUN are ignored; latched copies used until next Start.
REQ-023 Burst: after the final cycle of period number Count -> DONE; single/reserved: after first period -> DONE.
REQ-024 Continuous: stays in RUN until Stop; never enters DONE.
REQ-025 DONE lasts exactly one cycle: Done=1, Busy=0, Pulse=0, then IDLE; Start in DONE ignored.
REQ-026 Stop=1 in RUN or DONE -> IDLE next cycle, Pulse=0, Busy=0, Done=0; PeriodCount holds value.
REQ-027 Stop and final-period completion in same cycle -> Stop wins, no Done.
REQ-028 Start and Stop both high in IDLE -> no launch.
REQ-029 Start while Busy ignored; no restart, no re-latch.

Reset
REQ-030 Rst_n=0 at an edge -> IDLE, Pulse=0, Busy=0, Done=0, PeriodCount=0, phase=0, latched config=0, regardless of state.
REQ-031 Reset mid-run aborts without Done; Start in the same cycle as Rst_n=0 is ignored.
REQ-032 Asynchronous Rst_n edges have no effect until the next rising Clk.

Verification
REQ-033 Burst Ticks=3 Width=1 Count=3 -> Pulse high cycles t+1,t+5,t+9; Done at t+13; PeriodCount=3.
REQ-034 Continuous Ticks=2 Width=2, Stop after 7 cycles -> pattern 110110 1, then Pulse=0, Busy=0, no Done, PeriodCount=2.
REQ-035 Single Ticks=0 Width=5 -> Pulse high 1 cycle, Done next cycle; Mode=11 gives identical trace.
REQ-036 Burst Count=0 -> Done at t+1, Busy never high, Pulse never high.
REQ-037 Burst Ticks=4 Count=2, change Ticks to 1 and pulse Start mid-run -> original timing kept, Done at t+11.
REQ-038 Rst_n low during RUN of burst Count=5 -> all outputs 0 next cycle, no Done; fresh Start behaves per REQ-033 timing.

Source files
------------

// File: rtl/burst_pulse_generator.sv
`default_nettype none
// ============================================================================
//  Module      : burst_pulse_generator
//  Description : Programmable pulse-train generator. After a Start request it
//                emits periods of (Ticks+1) cycles with Width high cycles at
//                the start of each one, either continuously, for Count
//                periods, or for a single period, then strobes Done.
//  Revision    : 1.0  initial release
// ============================================================================
module burst_pulse_generator #(
   parameter int SIZE     = 8,
   parameter int CNT_SIZE = 8
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic                Start,
   input  logic                Stop,
   input  logic [1:0]          Mode,
   input  logic [SIZE-1:0]     Ticks,
   input  logic [SIZE-1:0]     Width,
   input  logic [CNT_SIZE-1:0] Count,
   output logic                Pulse,
   output logic                Busy,
   output logic                Done,
   output logic [CNT_SIZE-1:0] PeriodCount
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0] c_MODE_CONT  = 2'b00;
   localparam logic [1:0] c_MODE_BURST = 2'b01;

   state_t              r_state, w_state_nxt;
   logic [1:0]          r_mode, w_mode_nxt;
   logic [SIZE-1:0]     r_ticks, w_ticks_nxt;
   logic [SIZE-1:0]     r_width, w_width_nxt;
   logic [CNT_SIZE-1:0] r_count, w_count_nxt;
   logic [SIZE-1:0]     r_phase, w_phase_nxt;
   logic [CNT_SIZE-1:0] r_pc, w_pc_nxt;
   logic                r_pulse, w_pulse_nxt;
   logic                r_busy, w_busy_nxt;
   logic                r_done, w_done_nxt;

   logic                w_period_end;
   logic [SIZE-1:0]     w_phase_inc;
   logic [CNT_SIZE-1:0] w_pc_inc;
   logic                w_last_period;

   assign w_period_end = (r_phase == r_ticks);
   assign w_phase_inc  = r_phase + SIZE'(1);
   assign w_pc_inc     = r_pc + CNT_SIZE'(1);

   // Decide whether the period now ending is the final one of the run
   always_comb begin
      w_last_period = 1'b1;
      if (r_mode == c_MODE_CONT) begin
         w_last_period = 1'b0;
      end else if (r_mode == c_MODE_BURST) begin
         w_last_period = (w_pc_inc == r_count);
      end
   end

   // Next-state and next-output logic; outputs default low so IDLE/DONE exits are clean
   always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode;
      w_ticks_nxt = r_ticks;
      w_width_nxt = r_width;
      w_count_nxt = r_count;
      w_phase_nxt = r_phase;
      w_pc_nxt    = r_pc;
      w_pulse_nxt = 1'b0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (Start && !Stop) begin
               w_mode_nxt  = Mode;
               w_ticks_nxt = Ticks;
               w_width_nxt = Width;
               w_count_nxt = Count;
               w_phase_nxt = '0;
               w_pc_nxt    = '0;
               if ((Mode == c_MODE_BURST) && (Count == '0)) begin
                  // Empty burst: complete immediately without ever running
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = S_RUN;
                  w_busy_nxt  = 1'b1;
                  w_pulse_nxt = (Width != '0);
               end
            end
         end
         S_RUN: begin
            if (Stop) begin
               // Abort wins over a coinciding completion; PeriodCount holds
               w_state_nxt = S_IDLE;
            end else if (w_period_end) begin
               w_pc_nxt = w_pc_inc;
               if (w_last_period) begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_phase_nxt = '0;
                  w_busy_nxt  = 1'b1;
                  w_pulse_nxt = (r_width != '0);
               end
            end else begin
               w_phase_nxt = w_phase_inc;
               w_busy_nxt  = 1'b1;
               w_pulse_nxt = (w_phase_inc < r_width);
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and registered-output update with synchronous active-low reset
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         r_state <= S_IDLE;
         r_mode  <= '0;
         r_ticks <= '0;
         r_width <= '0;
         r_count <= '0;
         r_phase <= '0;
         r_pc    <= '0;
         r_pulse <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_mode  <= w_mode_nxt;
         r_ticks <= w_ticks_nxt;
         r_width <= w_width_nxt;
         r_count <= w_count_nxt;
         r_phase <= w_phase_nxt;
         r_pc    <= w_pc_nxt;
         r_pulse <= w_pulse_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign Pulse       = r_pulse;
   assign Busy        = r_busy;
   assign Done        = r_done;
   assign PeriodCount = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_burst_pulse_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_burst_pulse_generator
//  Description : Scoreboard bench for burst_pulse_generator. The driver
//                computes each run's expected per-cycle outputs from the
//                period arithmetic and queues them; a monitor compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_burst_pulse_generator;

   logic       Clk = 1'b0;
   logic       Rst_n = 1'b0;
   logic       Start = 1'b0;
   logic       Stop = 1'b0;
   logic [1:0] Mode = 2'b00;
   logic [7:0] Ticks = 8'd0;
   logic [7:0] Width = 8'd0;
   logic [7:0] Count = 8'd0;
   logic       Pulse;
   logic       Busy;
   logic       Done;
   logic [7:0] PeriodCount;

   logic [10:0] exp_q[$];
   logic [7:0]  pc_hold = 8'd0;
   int          n_checks = 0;
   int          n_pass = 0;
   int          n_cyc = 0;

   burst_pulse_generator #(.SIZE(8), .CNT_SIZE(8)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Stop(Stop), .Mode(Mode),
      .Ticks(Ticks), .Width(Width), .Count(Count), .Pulse(Pulse),
      .Busy(Busy), .Done(Done), .PeriodCount(PeriodCount)
   );

   // Free-running clock
   always #5 Clk = ~Clk;

   // Monitor: one queued expectation per cycle, checked mid-cycle
   always @(negedge Clk) begin
      logic [10:0] e;
      n_cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if ({Pulse, Busy, Done, PeriodCount} === e) begin
            n_pass++;
         end else begin
            $display("FAIL outputs cyc=%0d: got pulse=%b busy=%b done=%b pc=%0d, expected pulse=%b busy=%b done=%b pc=%0d",
                     n_cyc, Pulse, Busy, Done, PeriodCount, e[10], e[9], e[8], e[7:0]);
         end
      end
   end

   function automatic void push(input logic p, input logic b, input logic d, input logic [7:0] pc);
      exp_q.push_back({p, b, d, pc});
   endfunction

   // Random configuration and a random Start; never a Stop
   task automatic noise();
      Mode  = 2'($urandom);
      Ticks = 8'($urandom);
      Width = 8'($urandom);
      Count = 8'($urandom);
      Start = 1'($urandom_range(0, 1));
      Stop  = 1'b0;
   endtask

   // Idle cycles: Start only ever together with Stop, so no launch
   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         noise();
         Stop = Start;
         @(posedge Clk);
         push(1'b0, 1'b0, 1'b0, pc_hold);
         #1;
      end
   endtask

   // One launch. stop_at / rst_at: RUN cycle index (1-based) during which
   // Stop or reset is applied, 0 for none.
   task automatic do_run(input logic [1:0] m, input logic [7:0] t, input logic [7:0] w,
                         input logic [7:0] c, input int stop_at, input int rst_at);
      int p;
      int len;
      p = int'(t) + 1;
      if (m == 2'b00)      len = 0;
      else if (m == 2'b01) len = int'(c) * p;
      else                 len = p;
      Start = 1'b1; Stop = 1'b0; Mode = m; Ticks = t; Width = w; Count = c;
      @(posedge Clk);
      if (m == 2'b01 && c == 8'd0) begin
         pc_hold = 8'd0;
         push(1'b0, 1'b0, 1'b1, 8'd0);
         #1;
         noise();
         Stop = 1'($urandom_range(0, 1));
         @(posedge Clk);
         push(1'b0, 1'b0, 1'b0, pc_hold);
         #1;
         return;
      end
      for (int k = 1; k < 100000; k++) begin
         push(((k - 1) % p) < int'(w), 1'b1, 1'b0, 8'((k - 1) / p));
         #1;
         noise();
         if (k == rst_at)       Rst_n = 1'b0;
         else if (k == stop_at) Stop = 1'b1;
         @(posedge Clk);
         if (k == rst_at) begin
            pc_hold = 8'd0;
            push(1'b0, 1'b0, 1'b0, 8'd0);
            #1;
            Rst_n = 1'b1;
            break;
         end
         if (k == stop_at) begin
            pc_hold = 8'((k - 1) / p);
            push(1'b0, 1'b0, 1'b0, pc_hold);
            #1;
            break;
         end
         if (len != 0 && k == len) begin
            pc_hold = 8'(len / p);
            push(1'b0, 1'b0, 1'b1, pc_hold);
            #1;
            noise();
            Stop = 1'($urandom_range(0, 1));
            @(posedge Clk);
            push(1'b0, 1'b0, 1'b0, pc_hold);
            #1;
            break;
         end
      end
   endtask

   // Driver: directed corner runs, then randomized runs
   initial begin
      logic [1:0] m;
      logic [7:0] t, w, c;
      int         len, sa, ra;
      // Reset held with Start asserted: must stay idle and cleared
      Start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge Clk);
         push(1'b0, 1'b0, 1'b0, 8'd0);
         #1;
      end
      Rst_n = 1'b1;
      idle_cycles(3);
      do_run(2'b01, 8'd3, 8'd1, 8'd3, 0, 0);      // burst 3 periods of 4
      do_run(2'b00, 8'd2, 8'd2, 8'd0, 7, 0);      // continuous, stop after 7
      do_run(2'b10, 8'd0, 8'd5, 8'd0, 0, 0);      // single, 1-cycle period
      do_run(2'b11, 8'd0, 8'd5, 8'd0, 0, 0);      // reserved mode acts as single
      do_run(2'b01, 8'd6, 8'd2, 8'd0, 0, 0);      // empty burst
      do_run(2'b01, 8'd4, 8'd2, 8'd2, 0, 0);      // mid-run input churn ignored
      do_run(2'b01, 8'd3, 8'd1, 8'd5, 0, 7);      // reset mid-run
      do_run(2'b01, 8'd3, 8'd1, 8'd3, 0, 0);      // fresh run after reset
      do_run(2'b00, 8'd0, 8'd1, 8'd0, 300, 0);    // PeriodCount wraps
      do_run(2'b01, 8'd2, 8'd0, 8'd2, 6, 0);      // Stop on final cycle, Width=0
      do_run(2'b01, 8'd2, 8'd3, 8'd2, 0, 0);      // Width = Ticks+1
      do_run(2'b10, 8'd255, 8'd255, 8'd0, 0, 0);  // maximum period
      idle_cycles(2);
      for (int r = 0; r < 40; r++) begin
         m = 2'($urandom);
         t = 8'($urandom_range(0, 6));
         case ($urandom_range(0, 3))
            0:       w = 8'd0;
            1:       w = t + 8'd1;
            2:       w = 8'd255;
            default: w = 8'($urandom_range(0, int'(t) + 2));
         endcase
         c = 8'($urandom_range(0, 4));
         if (m == 2'b00)      len = $urandom_range(1, 30);
         else if (m == 2'b01) len = int'(c) * (int'(t) + 1);
         else                 len = int'(t) + 1;
         sa = 0;
         ra = 0;
         if (m == 2'b00)                                   sa = len;
         else if (len > 0 && $urandom_range(0, 2) == 0)    sa = $urandom_range(1, len);
         if (len > 0 && $urandom_range(0, 7) == 0)         ra = $urandom_range(1, len);
         do_run(m, t, w, c, sa, ra);
         idle_cycles($urandom_range(0, 2));
      end
      // Let the monitor drain the last expectations
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge Clk);
      #1;
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
